memory_bank_ctrl: RTL and testbench

//  Line-transfer sequencer between the cache controller and memory_bank (8 byte-wide banks, 8-byte lines).

---
 rtl/memory_bank_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_memory_bank_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bank_ctrl.sv
// memory_bank_ctrl
//   Line-transfer sequencer between the cache controller and memory_bank
//   (8 byte-wide banks, 8-byte lines). A single accepted request becomes a
//   timed memory_bank command sequence:
//     read  : one burst read (EN pulse), one wait cycle, then a SELECT sweep
//             0..7 whose DO bytes are streamed out on RD_DATA/RD_IDX.
//     write : eight single-byte writes; each byte gets an EN cycle followed
//             by a HOLD cycle with WE/ADDR/DI unchanged, because memory_bank
//             registers its bank enable and writes one cycle after EN.
//
// Ports
//   CLK, RST_N          clock (posedge), asynchronous active-low reset
//   REQ, REQ_WE,        request handshake; REQ held until ACK, REQ_WE and
//   REQ_ADDR            REQ_ADDR sampled at the accept edge
//   ACK, BUSY, DONE     accept pulse, not-idle flag, completion pulse
//   WR_READY, WR_DATA   write byte sampled at the end of a WR_READY cycle
//   RD_VALID, RD_DATA,  streamed read byte and its index within the line
//   RD_IDX
//   MB_EN, MB_WE,       memory_bank command outputs
//   MB_ADDR, MB_DI,
//   MB_SELECT
//   MB_DO               memory_bank DO_BUF (selected by MB_SELECT)
//
// Every output is a flop; the combinational block computes next-cycle
// values from the next state, so outputs line up with the state they
// belong to without any combinational path to the ports.
module memory_bank_ctrl #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 8,
    parameter int OFFSET_W = 3
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                REQ,
    input  logic                REQ_WE,
    input  logic [ADDR_W-1:0]   REQ_ADDR,
    output logic                ACK,
    output logic                BUSY,
    output logic                DONE,
    output logic                WR_READY,
    input  logic [DATA_W-1:0]   WR_DATA,
    output logic                RD_VALID,
    output logic [DATA_W-1:0]   RD_DATA,
    output logic [OFFSET_W-1:0] RD_IDX,
    output logic                MB_EN,
    output logic                MB_WE,
    output logic [ADDR_W-1:0]   MB_ADDR,
    output logic [DATA_W-1:0]   MB_DI,
    output logic [OFFSET_W-1:0] MB_SELECT,
    input  logic [DATA_W-1:0]   MB_DO
);

    localparam int LINE_W = ADDR_W - OFFSET_W;
    localparam logic [OFFSET_W-1:0] LAST_IDX = '1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_ISSUE,   // burst read EN pulse
        S_RD_WAIT,    // bank enables registered, RAM reads at end of cycle
        S_RD_STREAM,  // SELECT = cnt, DO captured at end of cycle
        S_RD_DONE,
        S_WR_FETCH,   // first write byte captured into MB_DI
        S_WR_EN,      // EN pulse for byte cnt
        S_WR_HOLD,    // RAM writes byte cnt at end of cycle
        S_WR_DONE
    } state_t;

    state_t              state_q, state_n;
    logic [OFFSET_W-1:0] cnt_q, cnt_n;
    logic [LINE_W-1:0]   line_q, line_n;

    logic                ack_n, busy_n, done_n, wr_ready_n, rd_valid_n;
    logic                mb_en_n, mb_we_n;
    logic [DATA_W-1:0]   rd_data_n, mb_di_n;
    logic [OFFSET_W-1:0] rd_idx_n, mb_select_n;
    logic [ADDR_W-1:0]   mb_addr_n;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            line_q    <= '0;
            ACK       <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            WR_READY  <= 1'b0;
            RD_VALID  <= 1'b0;
            RD_DATA   <= '0;
            RD_IDX    <= '0;
            MB_EN     <= 1'b0;
            MB_WE     <= 1'b0;
            MB_ADDR   <= '0;
            MB_DI     <= '0;
            MB_SELECT <= '0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            line_q    <= line_n;
            ACK       <= ack_n;
            BUSY      <= busy_n;
            DONE      <= done_n;
            WR_READY  <= wr_ready_n;
            RD_VALID  <= rd_valid_n;
            RD_DATA   <= rd_data_n;
            RD_IDX    <= rd_idx_n;
            MB_EN     <= mb_en_n;
            MB_WE     <= mb_we_n;
            MB_ADDR   <= mb_addr_n;
            MB_DI     <= mb_di_n;
            MB_SELECT <= mb_select_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        line_n     = line_q;
        mb_addr_n  = MB_ADDR;
        mb_di_n    = MB_DI;
        rd_data_n  = RD_DATA;
        rd_idx_n   = RD_IDX;
        rd_valid_n = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (REQ) begin
                    line_n    = REQ_ADDR[ADDR_W-1:OFFSET_W];
                    cnt_n     = '0;
                    mb_addr_n = {REQ_ADDR[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    state_n   = REQ_WE ? S_WR_FETCH : S_RD_ISSUE;
                end
            end
            S_RD_ISSUE: state_n = S_RD_WAIT;
            S_RD_WAIT: begin
                cnt_n   = '0;
                state_n = S_RD_STREAM;
            end
            S_RD_STREAM: begin
                // DO for SELECT=cnt is valid now; it leaves one cycle later
                rd_valid_n = 1'b1;
                rd_data_n  = MB_DO;
                rd_idx_n   = cnt_q;
                if (cnt_q == LAST_IDX) begin
                    state_n = S_RD_DONE;
                end else begin
                    cnt_n = cnt_q + OFFSET_W'(1);
                end
            end
            S_RD_DONE: state_n = S_IDLE;
            S_WR_FETCH: begin
                cnt_n   = '0;
                state_n = S_WR_EN;
            end
            S_WR_EN: state_n = S_WR_HOLD;
            S_WR_HOLD: begin
                if (cnt_q == LAST_IDX) begin
                    state_n = S_WR_DONE;
                end else begin
                    cnt_n     = cnt_q + OFFSET_W'(1);
                    mb_addr_n = {line_q, cnt_n};
                    state_n   = S_WR_EN;
                end
            end
            S_WR_DONE: state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase

        // Write byte is taken at the end of every WR_READY cycle, so it is
        // already on MB_DI when the following EN cycle begins.
        if (WR_READY) begin
            mb_di_n = WR_DATA;
        end

        ack_n       = (state_n == S_RD_ISSUE) || (state_n == S_WR_FETCH);
        busy_n      = (state_n != S_IDLE);
        done_n      = (state_n == S_RD_DONE) || (state_n == S_WR_DONE);
        mb_en_n     = (state_n == S_RD_ISSUE) || (state_n == S_WR_EN);
        mb_we_n     = (state_n == S_WR_EN) || (state_n == S_WR_HOLD);
        mb_select_n = (state_n == S_RD_STREAM) ? cnt_n : '0;
        wr_ready_n  = (state_n == S_WR_FETCH) ||
                      ((state_n == S_WR_HOLD) && (cnt_n != LAST_IDX));
    end

endmodule

// File: tb/tb_memory_bank_ctrl.sv
// Bench for memory_bank_ctrl: a behavioural memory_bank (registered enable,
// DO_BUF burst, single-byte write), a line-level reference memory, and a
// per-cycle expected-output function built from the transfer timetable.
module tb_memory_bank_ctrl;

    localparam int ADDR_W   = 14;
    localparam int DATA_W   = 8;
    localparam int OFFSET_W = 3;
    localparam int VW       = 43;

    logic                CLK = 1'b0;
    logic                RST_N;
    logic                REQ;
    logic                REQ_WE;
    logic [ADDR_W-1:0]   REQ_ADDR;
    logic                ACK, BUSY, DONE, WR_READY, RD_VALID;
    logic [DATA_W-1:0]   WR_DATA, RD_DATA, MB_DI, MB_DO;
    logic [OFFSET_W-1:0] RD_IDX, MB_SELECT;
    logic                MB_EN, MB_WE;
    logic [ADDR_W-1:0]   MB_ADDR;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    memory_bank_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OFFSET_W(OFFSET_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
        .ACK(ACK), .BUSY(BUSY), .DONE(DONE), .WR_READY(WR_READY), .WR_DATA(WR_DATA),
        .RD_VALID(RD_VALID), .RD_DATA(RD_DATA), .RD_IDX(RD_IDX),
        .MB_EN(MB_EN), .MB_WE(MB_WE), .MB_ADDR(MB_ADDR), .MB_DI(MB_DI),
        .MB_SELECT(MB_SELECT), .MB_DO(MB_DO)
    );

    // Power-on contents: line 0 holds 0x00..0x07.
    function automatic logic [7:0] init_val(input int a);
        logic [13:0] x;
        x = 14'(a);
        return x[7:0] ^ {2'b00, x[13:8]};
    endfunction

    // memory_bank model: enable registered, RAM acts one cycle after EN.
    logic [7:0] bank_mem [int];
    logic [7:0] do_buf [8];
    logic       en_q;

    function automatic logic [7:0] bank_rd(input int a);
        return bank_mem.exists(a) ? bank_mem[a] : init_val(a);
    endfunction

    always @(posedge CLK) begin
        en_q <= MB_EN;
        if (en_q) begin
            if (MB_WE) bank_mem[int'(MB_ADDR)] = MB_DI;
            else for (int b = 0; b < 8; b++)
                do_buf[b] <= bank_rd(int'({MB_ADDR[13:3], 3'(b)}));
        end
    end
    assign MB_DO = do_buf[MB_SELECT];

    // Reference memory at line granularity.
    logic [7:0] ref_mem [int];

    function automatic logic [63:0] ref_line(input logic [10:0] line);
        logic [63:0] v;
        int a;
        for (int k = 0; k < 8; k++) begin
            a = int'({line, 3'(k)});
            v[8*k +: 8] = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
        end
        return v;
    endfunction

    logic [VW-1:0] act;
    assign act = {ACK, BUSY, DONE, WR_READY, RD_VALID, RD_IDX, RD_DATA,
                  MB_EN, MB_WE, MB_ADDR, MB_DI, MB_SELECT};

    // Expected outputs in cycle c (c=0: idle) of a transfer.
    function automatic void expect_cycle(input logic we, input logic [10:0] line,
                                         input logic [63:0] bytes, input int c,
                                         output logic [VW-1:0] ev, output logic [VW-1:0] em);
        logic ack, busy, done, wrr, rv, en, mwe, m_rd, m_addr, m_di;
        logic [2:0] idx, sel;
        logic [7:0] rd, di;
        logic [13:0] addr;
        int k;
        ack = 0; busy = 0; done = 0; wrr = 0; rv = 0; en = 0; mwe = 0;
        m_rd = 0; m_addr = 0; m_di = 0; idx = 0; sel = 0; rd = 0; di = 0; addr = 0;
        if (c > 0) begin
            ack  = (c == 1);
            busy = 1'b1;
            if (we) begin
                k = (c - 2) / 2;
                if (k < 0) k = 0;
                if (k > 7) k = 7;
                done   = (c == 18);
                wrr    = (c == 1) || (c >= 3 && c <= 15 && (c % 2) == 1);
                en     = (c >= 2 && c <= 16 && (c % 2) == 0);
                mwe    = (c >= 2 && c <= 17);
                m_addr = mwe;
                m_di   = mwe;
                addr   = {line, 3'(k)};
                di     = bytes[8*k +: 8];
            end else begin
                done   = (c == 11);
                rv     = (c >= 4 && c <= 11);
                m_rd   = rv;
                if (rv) begin
                    idx = 3'(c - 4);
                    rd  = bytes[8*(c-4) +: 8];
                end
                en     = (c == 1);
                m_addr = 1'b1;
                addr   = {line, 3'b000};
                if (c >= 3 && c <= 10) sel = 3'(c - 3);
            end
        end
        ev = {ack, busy, done, wrr, rv, idx, rd, en, mwe, addr, di, sel};
        em = {5'b11111, {3{m_rd}}, {8{m_rd}}, 2'b11, {14{m_addr}}, {8{m_di}}, 3'b111};
    endfunction

    task automatic check_vec(input string name, input int c,
                             input logic [VW-1:0] ev, input logic [VW-1:0] em);
        checks++;
        if ((act & em) !== (ev & em)) begin
            errors++;
            $display("FAIL %s c%0d: got %h, expected %h (mask %h)", name, c, act & em, ev & em, em);
        end
    endtask

    // Called at a negedge with the DUT idle. Runs cycles 1..stop (0: whole
    // transfer plus the following idle cycle and reference update).
    task automatic run_txn(input string name, input logic we, input logic [13:0] addr,
                           input logic [63:0] bytes, input bit keep_req, input int stop);
        logic [VW-1:0] ev, em;
        logic en_p, we_p;
        logic [13:0] addr_p;
        logic [7:0] di_p;
        int len, wr_ptr;
        len = we ? 18 : 11;
        if (stop > 0) len = stop;
        wr_ptr = 0;
        en_p = 0; we_p = 0; addr_p = 0; di_p = 0;
        REQ = 1'b1; REQ_WE = we; REQ_ADDR = addr;
        for (int c = 1; c <= len; c++) begin
            @(negedge CLK);
            if (!keep_req) REQ = 1'b0;
            if (WR_READY && wr_ptr < 8) begin
                WR_DATA = bytes[8*wr_ptr +: 8];
                wr_ptr++;
            end
            expect_cycle(we, addr[13:3], bytes, c, ev, em);
            check_vec(name, c, ev, em);
            if (en_p) begin
                checks++;
                if (MB_EN !== 1'b0 || MB_ADDR !== addr_p || MB_WE !== we_p ||
                    (we_p && MB_DI !== di_p)) begin
                    errors++;
                    $display("FAIL %s hold c%0d: en=%b addr=%h we=%b di=%h, expected en=0 addr=%h we=%b di=%h",
                             name, c, MB_EN, MB_ADDR, MB_WE, MB_DI, addr_p, we_p, di_p);
                end
            end
            en_p = MB_EN; we_p = MB_WE; addr_p = MB_ADDR; di_p = MB_DI;
        end
        if (stop == 0) begin
            @(negedge CLK);
            expect_cycle(we, addr[13:3], bytes, 0, ev, em);
            check_vec({name, "-idle"}, 0, ev, em);
            if (we) for (int k = 0; k < 8; k++) ref_mem[int'({addr[13:3], 3'(k)})] = bytes[8*k +: 8];
        end
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [13:0] addr;
        logic [63:0] data;   // write bytes, or expected read bytes
    } vec_t;

    vec_t vecs [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] ev, em;
        logic [63:0] d;
        logic [10:0] ln;
        logic we;

        vecs[0] = '{"T1-wr-0x012", 1'b1, 14'h0090, 64'hA7A6A5A4A3A2A1A0};
        vecs[1] = '{"T1-rd-0x012", 1'b0, 14'h0090, 64'hA7A6A5A4A3A2A1A0};
        vecs[2] = '{"T2-rd-0x0097", 1'b0, 14'h0097, 64'hA7A6A5A4A3A2A1A0};
        vecs[3] = '{"T4-wr-0x7FF", 1'b1, 14'h3FF8, 64'h5555555555555555};
        vecs[4] = '{"T4-rd-0x000", 1'b0, 14'h0000, 64'h0706050403020100};
        vecs[5] = '{"T4-rd-0x7FF", 1'b0, 14'h3FFF, 64'h5555555555555555};

        RST_N = 1'b0; REQ = 1'b0; REQ_WE = 1'b0; REQ_ADDR = '0; WR_DATA = '0;
        repeat (3) @(negedge CLK);
        check_vec("reset", 0, '0, '1);
        RST_N = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 6; i++)
            run_txn(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].data, 1'b0, 0);

        // T3: REQ held through a write; the read behind it is accepted only
        // after one idle cycle.
        run_txn("T3-wr", 1'b1, 14'h0208, 64'h1122334455667788, 1'b1, 0);
        REQ_WE = 1'b0;
        run_txn("T3-rd", 1'b0, 14'h0208, 64'h1122334455667788, 1'b0, 0);

        // T5: reset right after byte 3's HOLD edge.
        run_txn("T5-wr", 1'b1, 14'h0800, 64'hC7C6C5C4C3C2C1C0, 1'b0, 9);
        @(posedge CLK);
        #1 RST_N = 1'b0;
        #1 check_vec("T5-async-reset", 9, '0, '1);
        for (int k = 0; k < 4; k++) ref_mem[int'({11'h100, 3'(k)})] = 8'hC0 + 8'(k);
        repeat (2) @(negedge CLK);
        check_vec("T5-reset-held", 0, '0, '1);
        RST_N = 1'b1;
        @(negedge CLK);
        d = ref_line(11'h100);
        run_txn("T5-rd", 1'b0, 14'h0800, d, 1'b0, 0);

        // Randomised traffic over a few lines, including the top line.
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            ln = ($urandom_range(0, 7) == 0) ? 11'h7FF : 11'($urandom_range(0, 5));
            d  = we ? {$urandom, $urandom} : ref_line(ln);
            run_txn(we ? "rand-wr" : "rand-rd", we, {ln, 3'($urandom_range(0, 7))}, d, 1'b0, 0);
            repeat ($urandom_range(0, 2)) begin
                @(negedge CLK);
                expect_cycle(1'b0, ln, d, 0, ev, em);
                check_vec("rand-gap", 0, ev, em);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
